uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, meaning clk cycles per serial bit (100 MHz / 9600 baud).
REQ-002 SHALL have parameter PARITY_EN, default 1, meaning 1 inserts an even-parity bit after the data bits and 0 omits it.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port data, input, 8 bits: byte to send, LSB first.
REQ-006 SHALL have port data_valid, input, 1 bit: data holds a byte to send.
REQ-007 SHALL have port data_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a frame.

Function
REQ-011 SHALL accept a byte on any rising edge where data_valid=1 and data_ready=1, latching data into an internal shift register; data may change after acceptance.
REQ-012 SHALL drive data_ready=1 only in IDLE, combinationally from state.
REQ-013 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
- Transitions: IDLE->START on accept; START->DATA; DATA->PARITY after bit 7, or DATA->STOP when PARITY_EN=0; PARITY->STOP; STOP->IDLE.
- Every non-IDLE state lasts exactly CLKS_PER_BIT cycles.
REQ-014 SHALL drive tx as a registered output with these values: IDLE=1, START=0, DATA=the current shift-register LSB, PARITY=XOR of the 8 latched bits, STOP=1.
REQ-015 SHALL drive tx low on the first cycle after the accept edge; latency from accept to the start-bit edge is 1 clk.
REQ-016 SHALL make the frame length exactly 11*CLKS_PER_BIT cycles with PARITY_EN=1, and 10*CLKS_PER_BIT with PARITY_EN=0.
REQ-017 SHALL use a baud counter that counts 0..CLKS_PER_BIT-1, wraps to 0, and asserts an internal bit_tick on the value CLKS_PER_BIT-1.
- The counter SHALL hold at 0 in IDLE and restart at 0 on accept.
- The counter width SHALL be $clog2(CLKS_PER_BIT).
REQ-018 SHALL use a 3-bit bit index counting 0..7 in DATA; the shift register SHALL shift right on each bit_tick in DATA.
REQ-019 SHALL pulse done=1 for exactly one cycle on the STOP->IDLE transition; data_ready SHALL be 1 in the same cycle.
REQ-020 SHALL, when data_valid is held high continuously, accept the next byte in the cycle after done, giving a 1-clk idle-high gap between the stop bit and the next start bit.
REQ-021 SHALL ignore data_valid while busy=1: no latching, no queueing, and the frame in progress is not corrupted.
REQ-022 SHALL make busy=1 exactly when state is not IDLE.
REQ-023 SHALL support CLKS_PER_BIT=1, with each bit lasting one cycle.

Reset
REQ-024 SHALL, when rst=1 on a clock edge, set state=IDLE, tx=1, busy=0, done=0, the counters to 0 and the shift register to 0.
REQ-025 SHALL, on reset during a frame, return tx to 1 on the next cycle and discard the frame; no done pulse is generated.
REQ-026 SHALL ignore data_valid on any edge where rst=1.

Structure
REQ-027 SHALL place the state encoding (localparams IDLE..STOP), DATA_W=8 and the default CLKS_PER_BIT in a shared uart_pkg, which the receiver also uses.
REQ-028 SHALL instantiate one sub-module, uart_baud_tick (counter, enable input, bit_tick output), reusable by the receiver; all other logic SHALL be inline.

Verification (CLKS_PER_BIT=4, PARITY_EN=1 unless stated)
REQ-029 Send 0x59 -> tx = 0,1,0,0,1,1,0,1,0,0,1, each bit 4 clks; done pulses at cycle 44 after accept.
REQ-030 Send 0xBA, then 0xBF with data_valid held high -> bits 0x0, 0,1,0,1,1,1,0,1, parity 1, stop 1; next start bit 1 clk after done; 0xBF parity=1.
REQ-031 With PARITY_EN=0, send 0x00 -> tx low for 36 clks, then high for 4 clks; frame is 40 clks.
REQ-032 Assert rst at cycle 17 of the 0xFF frame -> tx=1 next cycle, busy=0, no done; a following send of 0x59 is bit-exact as in REQ-029.
REQ-033 Pulse data_valid with 0x12 while busy -> ignored; the current frame is unchanged and 0x12 is never transmitted.
REQ-034 Loopback of uart_tx into the existing uart receiver (CLKS_PER_BIT=10417 vs the receiver's divided clock) for 0x59, 0xBA and 0xBF -> receiver data matches each byte with data_valid asserted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding for the tx and rx paths.
// Holds frame width, default bit period and the baud counter width helper.
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;
  localparam int CLKS_PER_BIT_DEF = 10417;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // A one-cycle bit period still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled, held at 0 otherwise.
// Ports: clk, rst (sync, high), en_i, tick_o (high on the last count).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Ports: clk, rst, data/data_valid/data_ready in, tx line, busy, done pulse.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  uart_state_e state_q;
  uart_state_e state_d;

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic              par_q;
  logic              par_d;
  logic              tx_q;
  logic              tx_d;
  logic              done_q;
  logic              done_d;
  logic              bit_tick;
  logic              accept;

  assign data_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign accept     = data_valid && data_ready;
  assign tx         = tx_q;
  assign done       = done_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .en_i  (busy),
    .tick_o(bit_tick)
  );

  // tx_d is the line value for the state being entered, so the
  // registered tx changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = START;
          shift_d = data;
          par_d   = ^data;
          idx_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame traces, handshake, reset abort, parity off,
// one-cycle bit period, and a serial monitor checked against a byte queue.
module tb_uart_tx;

  localparam int N  = 4;
  localparam int FL = 11 * N;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] d0_data;
  logic       d0_valid;
  logic       d0_ready;
  logic       d0_tx;
  logic       d0_busy;
  logic       d0_done;

  logic [7:0] d1_data;
  logic       d1_valid;
  logic       d1_ready;
  logic       d1_tx;
  logic       d1_busy;
  logic       d1_done;

  int n_cmp = 0;
  int n_err = 0;
  int kill_cnt = 0;
  logic [7:0] sb[$];

  uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .tx(tx), .busy(busy), .done(done)
  );

  uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .data(d0_data), .data_valid(d0_valid),
    .data_ready(d0_ready), .tx(d0_tx), .busy(d0_busy), .done(d0_done)
  );

  uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .data(d1_data), .data_valid(d1_valid),
    .data_ready(d1_ready), .tx(d1_tx), .busy(d1_busy), .done(d1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_trace(input logic [7:0] b,
                                            input int n, input bit par);
    logic [10:0] fb;
    logic [63:0] t;
    int nb;
    t  = '0;
    fb = par ? {1'b1, ^b, b, 1'b0} : {1'b1, 1'b1, b, 1'b0};
    nb = par ? 11 : 10;
    for (int k = 0; k < nb * n; k++) t[k] = fb[k / n];
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] b, input bit hold);
    int w;
    w = 0;
    while (!data_ready && w < 200) begin
      step();
      w++;
    end
    chk("rdy_wait", data_ready, 1);
    data       = b;
    data_valid = 1'b1;
    sb.push_back(b);
    step();
    if (!hold) data_valid = 1'b0;
  endtask

  // Entered #1 after the accept edge; leaves in the done cycle.
  task automatic watch_frame(input logic [7:0] b, input int inj_k,
                             input logic [7:0] inj_b);
    logic [63:0] tr;
    logic early;
    tr    = '0;
    early = 1'b0;
    chk("start_lat", tx, 0);
    chk("busy_acc", busy, 1);
    chk("rdy_busy", data_ready, 0);
    for (int k = 0; k < FL; k++) begin
      if (inj_k >= 0 && k == inj_k) begin
        data       = inj_b;
        data_valid = 1'b1;
      end
      if (inj_k >= 0 && k == inj_k + 1) data_valid = 1'b0;
      tr[k] = tx;
      early = early | done;
      step();
    end
    chk("trace", tr, exp_trace(b, N, 1'b1));
    chk("no_early_done", early, 0);
    chk("done", done, 1);
    chk("rdy_done", data_ready, 1);
    chk("busy_done", busy, 0);
    chk("tx_idle", tx, 1);
  endtask

  // Receiver model: mid-bit sampling of the serial line.
  initial begin : mon
    logic [7:0] rb;
    logic [7:0] eb;
    logic rs0;
    logic rp;
    logic rs;
    int kc;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        kc = kill_cnt;
        repeat (2) @(negedge clk);
        rs0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (N) @(negedge clk);
          rb[i] = tx;
        end
        repeat (N) @(negedge clk);
        rp = tx;
        repeat (N) @(negedge clk);
        rs = tx;
        if (kill_cnt != kc) continue;
        chk("rx_sb_empty", (sb.size() == 0), 0);
        if (sb.size() != 0) begin
          eb = sb.pop_front();
          chk("rx_start", rs0, 0);
          chk("rx_data", rb, eb);
          chk("rx_par", rp, ^eb);
          chk("rx_stop", rs, 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [63:0] tr;
    logic dn;
    rst        = 1'b1;
    data       = '0;
    data_valid = 1'b0;
    d0_data    = '0;
    d0_valid   = 1'b0;
    d1_data    = '0;
    d1_valid   = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdy", data_ready, 1);

    accept(8'h59, 1'b0);
    watch_frame(8'h59, -1, 8'h00);
    step();

    accept(8'hBA, 1'b1);
    data = 8'hBF;
    watch_frame(8'hBA, -1, 8'h00);
    sb.push_back(8'hBF);
    step();
    data_valid = 1'b0;
    watch_frame(8'hBF, -1, 8'h00);
    step();

    accept(8'h3C, 1'b0);
    watch_frame(8'h3C, 10, 8'h12);
    step();

    accept(8'hFF, 1'b0);
    repeat (17) step();
    rst        = 1'b1;
    data       = 8'h12;
    data_valid = 1'b1;
    void'(sb.pop_back());
    kill_cnt++;
    step();
    rst        = 1'b0;
    data_valid = 1'b0;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rdy", data_ready, 1);
    dn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      dn = dn | done | busy | ~tx;
      step();
    end
    chk("abort_quiet", dn, 0);
    accept(8'h59, 1'b0);
    watch_frame(8'h59, -1, 8'h00);

    d0_data  = 8'h00;
    d0_valid = 1'b1;
    step();
    d0_valid = 1'b0;
    tr = '0;
    dn = 1'b0;
    for (int k = 0; k < 10 * N; k++) begin
      tr[k] = d0_tx;
      dn    = dn | d0_done;
      step();
    end
    chk("p0_trace", tr, 64'h0000_00F0_0000_0000);
    chk("p0_early", dn, 0);
    chk("p0_done", d0_done, 1);
    chk("p0_tx", d0_tx, 1);

    d1_data  = 8'h59;
    d1_valid = 1'b1;
    step();
    d1_valid = 1'b0;
    tr = '0;
    dn = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tr[k] = d1_tx;
      dn    = dn | d1_done;
      step();
    end
    chk("n1_trace", tr, 64'h0000_0000_0000_04B2);
    chk("n1_early", dn, 0);
    chk("n1_done", d1_done, 1);

    repeat (60) step();
    chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
